serial_comparator: RTL and testbench

Parametrised, multi-cycle magnitude comparator for two WIDTH-bit operands, with an unsigned or two's-complement mode selected per operation. It scans the operands MSB-first, CHUNK bits per cycle, and terminates early at the first differing chunk. Results are reported on registered one-hot g/e/s flags under a start/busy/done handshake. It is the sequential, wide-operand successor to the single-bit combinational comparator, for datapaths where a full-width compare would break timing.

---
 rtl/serial_comparator_if.sv | 30 +++
 rtl/serial_comparator.sv | 98 +++++++++
 tb/tb_serial_comparator.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_comparator_if.sv
// Start/busy/done handshake bundle for serial_comparator.
// master: issues start/operands; slave: returns busy/done/g/e/s/cycles.
interface serial_comparator_if #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = $clog2(NCH + 1);

    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             g;
    logic             e;
    logic             s;
    logic [CW-1:0]    cycles;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, g, e, s, cycles
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, g, e, s, cycles
    );
endinterface

// File: rtl/serial_comparator.sv
// Multi-cycle MSB-first magnitude comparator, CHUNK bits per cycle.
// Ports: clk, rst_n (sync, active low), bus (slave: start/a/b/mode in, busy/done/g/e/s/cycles out).
module serial_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_comparator_if.slave  bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = $clog2(NCH + 1);
    localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    k_q;
    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic             last;
    logic             decide;
    logic             busy;
    logic             done_q;
    logic             g_q;
    logic             e_q;
    logic             s_q;
    logic [CW-1:0]    cyc_q;

    // Operands are shifted left as chunks match, so the chunk under
    // test is always the top CHUNK bits of the captured registers.
    assign ca     = a_q[WIDTH-1 -: CHUNK];
    assign cb     = b_q[WIDTH-1 -: CHUNK];
    assign last   = (k_q == CW'(NCH - 1));
    assign decide = (state_q == RUN) && ((ca != cb) || last);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.start) state_d = RUN;
            RUN:  if (decide)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            k_q    <= '0;
            done_q <= 1'b0;
            g_q    <= 1'b0;
            e_q    <= 1'b0;
            s_q    <= 1'b0;
            cyc_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (bus.start) begin
                    // Offset-binary: flipping both sign bits turns a
                    // signed ordering into an unsigned one.
                    a_q <= bus.a ^ (bus.signed_mode ? MSB : '0);
                    b_q <= bus.b ^ (bus.signed_mode ? MSB : '0);
                    k_q <= '0;
                end
            end else if (decide) begin
                g_q    <= (ca > cb);
                e_q    <= (ca == cb);
                s_q    <= (ca < cb);
                cyc_q  <= k_q + CW'(1);
                done_q <= 1'b1;
            end else begin
                a_q <= a_q << CHUNK;
                b_q <= b_q << CHUNK;
                k_q <= k_q + CW'(1);
            end
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done_q;
    assign bus.g      = g_q;
    assign bus.e      = e_q;
    assign bus.s      = s_q;
    assign bus.cycles = cyc_q;
endmodule

// File: tb/tb_serial_comparator.sv
// Directed bench for serial_comparator: 16/4 main instance,
// plus 1/1 and 8/2 instances for the parameter sweep.
module tb_serial_comparator;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    serial_comparator_if #(.WIDTH(16), .CHUNK(4)) m16 ();
    serial_comparator_if #(.WIDTH(1),  .CHUNK(1)) m1 ();
    serial_comparator_if #(.WIDTH(8),  .CHUNK(2)) m8 ();

    serial_comparator #(.WIDTH(16), .CHUNK(4)) u16 (
        .clk(clk), .rst_n(rst_n), .bus(m16));
    serial_comparator #(.WIDTH(1), .CHUNK(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(m1));
    serial_comparator #(.WIDTH(8), .CHUNK(2)) u8 (
        .clk(clk), .rst_n(rst_n), .bus(m8));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] snap16();
        return 32'({m16.busy, m16.done, m16.g, m16.e, m16.s, m16.cycles});
    endfunction

    task automatic wait16(output int n);
        n = 0;
        while (!m16.done && n < 20) begin
            tick();
            n++;
        end
        if (!m16.done) check("timeout16", 32'(m16.done), 32'd1);
    endtask

    task automatic run16(input string tag, input logic [15:0] ta,
                         input logic [15:0] tbv, input logic sm,
                         input logic [2:0] ges, input int cyc);
        int n;
        m16.a = ta;
        m16.b = tbv;
        m16.signed_mode = sm;
        m16.start = 1'b1;
        tick();
        m16.start = 1'b0;
        check({tag, ".busy"}, 32'(m16.busy), 32'd1);
        wait16(n);
        check({tag, ".lat"}, n, cyc);
        check({tag, ".ges"}, 32'({m16.g, m16.e, m16.s}), 32'(ges));
        check({tag, ".cyc"}, 32'(m16.cycles), cyc);
        check({tag, ".idle"}, 32'(m16.busy), 32'd0);
        tick();
        check({tag, ".pulse"}, 32'(m16.done), 32'd0);
    endtask

    // Reference for the 8/2 configuration: {g,e,s,cycles[2:0]}
    function automatic logic [5:0] ref8(input logic [7:0] x,
                                        input logic [7:0] y,
                                        input logic sm);
        logic [7:0] xx;
        logic [7:0] yy;
        logic [1:0] cx;
        logic [1:0] cy;
        xx = x;
        yy = y;
        if (sm) begin
            xx[7] = ~xx[7];
            yy[7] = ~yy[7];
        end
        for (int k = 0; k < 4; k++) begin
            cx = xx[7-2*k -: 2];
            cy = yy[7-2*k -: 2];
            if (cx > cy) return {3'b100, 3'(k + 1)};
            if (cx < cy) return {3'b001, 3'(k + 1)};
        end
        return {3'b010, 3'd4};
    endfunction

    initial begin
        #3000000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [5:0] exp8;
        logic [0:0] wa [4];
        logic [0:0] wb [4];
        logic [2:0] wg [4];

        rst_n = 1'b0;
        m16.start = 1'b1; m16.a = 16'h1234; m16.b = 16'h0;
        m16.signed_mode = 1'b0;
        m1.start = 1'b1; m1.a = 1'b1; m1.b = 1'b0; m1.signed_mode = 1'b0;
        m8.start = 1'b1; m8.a = 8'h0; m8.b = 8'h1; m8.signed_mode = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst16", snap16(), 32'd0);
        end
        check("rst1", 32'({m1.busy, m1.done, m1.g, m1.e, m1.s, m1.cycles}), 0);
        check("rst8", 32'({m8.busy, m8.done, m8.g, m8.e, m8.s, m8.cycles}), 0);

        m16.start = 1'b0; m1.start = 1'b0; m8.start = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_idle", snap16(), 32'd0);

        run16("eq",     16'h1234, 16'h1234, 1'b0, 3'b010, 4);
        run16("early_g", 16'h12F0, 16'h12E0, 1'b0, 3'b100, 3);
        run16("early_s", 16'h12E0, 16'h12F0, 1'b0, 3'b001, 3);
        run16("mode_u", 16'h8000, 16'h7FFF, 1'b0, 3'b100, 1);
        run16("mode_s", 16'h8000, 16'h7FFF, 1'b1, 3'b001, 1);
        run16("neg1_s", 16'hFFFF, 16'h0001, 1'b1, 3'b001, 1);

        // start and operand changes during RUN are ignored
        m16.a = 16'h1234; m16.b = 16'h1234; m16.signed_mode = 1'b0;
        m16.start = 1'b1;
        tick();
        m16.start = 1'b0;
        tick();
        m16.start = 1'b1; m16.a = 16'h0000; m16.b = 16'hFFFF;
        m16.signed_mode = 1'b1;
        tick();
        m16.start = 1'b0;
        wait16(n);
        check("ign.ges", 32'({m16.g, m16.e, m16.s}), 32'b010);
        check("ign.cyc", 32'(m16.cycles), 32'd4);
        tick();
        check("ign.noqueue", 32'(m16.busy), 32'd0);

        // back-to-back: start in the done cycle
        m16.a = 16'h12F0; m16.b = 16'h12E0; m16.signed_mode = 1'b0;
        m16.start = 1'b1;
        tick();
        m16.start = 1'b0;
        wait16(n);
        check("b2b1.ges", 32'({m16.g, m16.e, m16.s}), 32'b100);
        m16.a = 16'h0005; m16.b = 16'h0007; m16.start = 1'b1;
        tick();
        m16.start = 1'b0;
        check("b2b.busy", 32'({m16.busy, m16.done}), 32'b10);
        check("b2b.hold", 32'({m16.g, m16.e, m16.s, m16.cycles}), 32'b100_011);
        wait16(n);
        check("b2b2.lat", n, 32'd4);
        check("b2b2.res", 32'({m16.g, m16.e, m16.s, m16.cycles}), 32'b001_100);
        tick();

        // reset mid-RUN abandons the compare
        m16.a = 16'h1234; m16.b = 16'h1234; m16.start = 1'b1;
        tick();
        m16.start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst", snap16(), 32'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | m16.done | m16.busy;
        end
        check("midrst.nodone", 32'(seen), 32'd0);
        check("midrst.zero", snap16(), 32'd0);

        // WIDTH=1, CHUNK=1
        wa = '{1'b1, 1'b0, 1'b0, 1'b1};
        wb = '{1'b0, 1'b1, 1'b0, 1'b1};
        wg = '{3'b100, 3'b001, 3'b010, 3'b010};
        for (int i = 0; i < 4; i++) begin
            m1.a = wa[i]; m1.b = wb[i]; m1.signed_mode = 1'b0;
            m1.start = 1'b1;
            tick();
            m1.start = 1'b0;
            check("w1.busy", 32'({m1.busy, m1.done}), 32'b10);
            tick();
            check("w1.res", 32'({m1.busy, m1.done, m1.g, m1.e, m1.s, m1.cycles}),
                  32'({2'b01, wg[i], 1'b1}));
        end

        // WIDTH=8, CHUNK=2 random sweep, both modes
        for (int md = 0; md < 2; md++) begin
            for (int i = 0; i < 1000; i++) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                if (i % 8 == 0) rb = ra;
                exp8 = ref8(ra, rb, md[0]);
                m8.a = ra; m8.b = rb; m8.signed_mode = md[0];
                m8.start = 1'b1;
                tick();
                m8.start = 1'b0;
                n = 0;
                while (!m8.done && n < 10) begin
                    tick();
                    n++;
                end
                check("w8.res", 32'({m8.g, m8.e, m8.s, m8.cycles}), 32'(exp8));
                check("w8.lat", n, 32'(exp8[2:0]));
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
